// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bundle: EX branch resolution inputs, hazard/imem handshake,
// and the PC/flush/status outputs presented to the IF stage.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 16
);
  logic              unconditional_branch_in;
  logic              conditional_branch_in;
  logic              alu_main_is_zero_in;
  logic              branch_valid_in;
  logic [ADDR_W-1:0] branch_target_in;
  logic              stall_in;
  logic              imem_ready_in;
  logic              imem_req_out;
  logic [ADDR_W-1:0] pc_out;
  logic              pc_src_out;
  logic              flush_if_id_out;
  logic              flush_id_ex_out;
  logic              misalign_err_out;
  logic [CNT_W-1:0]  taken_count_out;

  modport master (
    output unconditional_branch_in, conditional_branch_in, alu_main_is_zero_in,
           branch_valid_in, branch_target_in, stall_in, imem_ready_in,
    input  imem_req_out, pc_out, pc_src_out, flush_if_id_out, flush_id_ex_out,
           misalign_err_out, taken_count_out
  );

  modport slave (
    input  unconditional_branch_in, conditional_branch_in, alu_main_is_zero_in,
           branch_valid_in, branch_target_in, stall_in, imem_ready_in,
    output imem_req_out, pc_out, pc_src_out, flush_if_id_out, flush_id_ex_out,
           misalign_err_out, taken_count_out
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: resolves EX branches, redirects fetch, and issues
// registered flush pulses for the wrong-path slots.
module pc_sequencer #(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       FLUSH_SLOTS = 2,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [2:0] SLOTS    = 3'(FLUSH_SLOTS);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic              src_q, src_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        slot_q, slot_d;
  logic              taken;

  // Outputs are computed one cycle ahead so every port is a flop.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = 1'b0;
    src_d   = 1'b0;
    flush_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    taken   = bus.branch_valid_in &
              (bus.unconditional_branch_in |
               (bus.conditional_branch_in & bus.alu_main_is_zero_in));
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_FETCH: begin
        if (taken) begin
          pc_d    = {bus.branch_target_in[ADDR_W-1:2], 2'b00};
          src_d   = 1'b1;
          if (bus.branch_target_in[1:0] != 2'b00) err_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          slot_d  = SLOTS;
          flush_d = 1'b1;
          state_d = ST_FLUSH;
        end else begin
          req_d = 1'b1;
          if (!bus.stall_in && bus.imem_ready_in) pc_d = pc_q + ADDR_W'(4);
        end
      end
      ST_FLUSH: begin
        slot_d = slot_q - 3'd1;
        if (slot_q == 3'd1) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      src_q   <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      src_q   <= src_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  assign bus.imem_req_out     = req_q;
  assign bus.pc_out           = pc_q;
  assign bus.pc_src_out       = src_q;
  assign bus.flush_if_id_out  = flush_q;
  assign bus.flush_id_ex_out  = flush_q;
  assign bus.misalign_err_out = err_q;
  assign bus.taken_count_out  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected post-edge
// outputs from a phase/counter model; a monitor pops and compares each cycle.
module tb_pc_sequencer;
  localparam int unsigned AW = 64;
  localparam int unsigned SLOTS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(AW), .CNT_W(16)) bus  ();
  pc_sequencer_if #(.ADDR_W(AW), .CNT_W(2))  bus2 ();

  pc_sequencer #(.ADDR_W(AW), .RESET_PC(64'h0), .FLUSH_SLOTS(SLOTS), .CNT_W(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  pc_sequencer #(.ADDR_W(AW), .RESET_PC(64'h0), .FLUSH_SLOTS(SLOTS), .CNT_W(2)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus2));

  typedef struct {
    logic [AW-1:0] pc;
    logic req, src, flush, err;
    logic [63:0] cnt, cnt2;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Reference model: abstract phase bookkeeping.
  bit            m_idle;
  int            m_flush_left;
  logic [AW-1:0] m_pc;
  bit            m_src, m_err;
  int            m_taken;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pc    = m_pc;
    e.req   = (!m_idle && m_flush_left == 0);
    e.src   = m_src;
    e.flush = (m_flush_left > 0);
    e.err   = m_err;
    e.cnt   = (m_taken > 65535) ? 64'd65535 : 64'(m_taken);
    e.cnt2  = (m_taken > 3) ? 64'd3 : 64'(m_taken);
    return e;
  endfunction

  // Caller sits at a negedge; drive, predict, push, then advance one cycle.
  task automatic cyc(input logic ub, input logic cb, input logic z, input logic v,
                     input logic [AW-1:0] tgt, input logic st, input logic rdy);
    bit tk;
    bus.unconditional_branch_in = ub;  bus2.unconditional_branch_in = ub;
    bus.conditional_branch_in   = cb;  bus2.conditional_branch_in   = cb;
    bus.alu_main_is_zero_in     = z;   bus2.alu_main_is_zero_in     = z;
    bus.branch_valid_in         = v;   bus2.branch_valid_in         = v;
    bus.branch_target_in        = tgt; bus2.branch_target_in        = tgt;
    bus.stall_in                = st;  bus2.stall_in                = st;
    bus.imem_ready_in           = rdy; bus2.imem_ready_in           = rdy;
    m_src = 0;
    if (m_idle) begin
      m_idle = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      tk = v && (ub || (cb && z));
      if (tk) begin
        m_pc = tgt & ~64'h3;
        m_src = 1;
        if (tgt[1:0] != 2'b00) m_err = 1;
        m_taken++;
        m_flush_left = SLOTS;
      end else if (!st && rdy) begin
        m_pc = m_pc + 64'd4;
      end
    end
    exp_q.push_back(snapshot());
    mon_en = 1;
    @(negedge clk);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 64'h0, 0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"},    bus.pc_out, 64'h0);
    chk({tag, "_req"},   bus.imem_req_out, 0);
    chk({tag, "_src"},   bus.pc_src_out, 0);
    chk({tag, "_fifid"}, bus.flush_if_id_out, 0);
    chk({tag, "_fidex"}, bus.flush_id_ex_out, 0);
    chk({tag, "_err"},   bus.misalign_err_out, 0);
    chk({tag, "_cnt"},   bus.taken_count_out, 0);
    chk({tag, "_cnt2"},  bus2.taken_count_out, 0);
  endtask

  // Called at a negedge; reset is asserted mid-phase so no clock edge helps it.
  task automatic do_reset();
    mon_en = 0;
    exp_q.delete();
    #3 rst_n = 1'b0;
    #1 check_reset_values("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_values("rst_idle");
    m_idle = 1; m_flush_left = 0; m_pc = '0; m_src = 0; m_err = 0; m_taken = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL queue_empty actual=0 required=1 t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pc",    bus.pc_out, e.pc);
          chk("req",   bus.imem_req_out, e.req);
          chk("src",   bus.pc_src_out, e.src);
          chk("fifid", bus.flush_if_id_out, e.flush);
          chk("fidex", bus.flush_id_ex_out, e.flush);
          chk("err",   bus.misalign_err_out, e.err);
          chk("cnt",   bus.taken_count_out, e.cnt);
          chk("cnt2",  bus2.taken_count_out, e.cnt2);
          chk("pc2",   bus2.pc_out, e.pc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [AW-1:0] t;
    idle_cyc(0);
    @(negedge clk);
    do_reset();
    // Sequential fetch, ready back-pressure and stall holds.
    idle_cyc(3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 64'h0, 0, 0);
    cyc(0, 0, 0, 0, 64'h0, 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 64'h0, 1, 1);
    cyc(0, 0, 0, 0, 64'h0, 0, 1);
    // Conditional branch not taken, then taken.
    cyc(0, 1, 0, 1, 64'h100, 0, 1);
    cyc(0, 1, 1, 1, 64'h100, 0, 1);
    idle_cyc(4);
    // Unconditional branch beats stall; misaligned target.
    cyc(1, 0, 0, 1, 64'h203, 1, 0);
    idle_cyc(4);
    // Both branch types with zero=0, and valid=0 suppression.
    cyc(0, 0, 0, 0, 64'h0, 0, 1);
    cyc(1, 1, 0, 0, 64'h500, 0, 1);
    cyc(1, 1, 0, 1, 64'h600, 0, 1);
    idle_cyc(3);
    // Second taken branch during flush is ignored.
    cyc(1, 0, 0, 1, 64'h300, 0, 1);
    cyc(1, 0, 0, 1, 64'h400, 0, 1);
    cyc(0, 1, 1, 1, 64'h404, 0, 0);
    idle_cyc(2);
    // Reset in the middle of a flush.
    cyc(1, 0, 0, 1, 64'h700, 0, 1);
    do_reset();
    idle_cyc(1);
    // Wrap from the top of the address space.
    cyc(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
    idle_cyc(4);
    // Counter saturation on the narrow instance.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1, 64'(32'h1000 + 32'(i) * 32'h40), 0, 1);
      idle_cyc(3);
    end
    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
      end
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), t,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
    end
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the core.
- Resolves the EX-stage branch decision from the unconditional-branch, conditional-branch and ALU zero signals, then redirects the PC.
- Drives pipeline flush pulses for the wrong-path slots, and respects hazard stalls and instruction-memory back-pressure.
- Sits between the control/ALU outputs and the IF stage, replacing the free-running PC register plus PC mux select.

Parameters:
- ADDR_W, 64, PC and branch target width.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_SLOTS, 2, cycles of flush asserted after a taken branch (1..7).
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- unconditional_branch_in  input  1  EX instruction is an unconditional branch.
- conditional_branch_in  input  1  EX instruction is a conditional (zero-test) branch.
- alu_main_is_zero_in  input  1  main ALU result is zero.
- branch_valid_in  input  1  EX slot holds a valid instruction.
- branch_target_in  input  ADDR_W  EX-computed branch target.
- stall_in  input  1  hazard unit load-use stall; hold PC.
- imem_ready_in  input  1  instruction memory accepts the current request.
- imem_req_out  output  1  fetch request valid for pc_out.
- pc_out  output  ADDR_W  current fetch address.
- pc_src_out  output  1  registered one-cycle pulse: PC was just loaded from a branch target.
- flush_if_id_out  output  1  kill the IF/ID register.
- flush_id_ex_out  output  1  kill the ID/EX register.
- misalign_err_out  output  1  sticky: a taken target had bits [1:0] != 0.
- taken_count_out  output  CNT_W  saturating count of taken branches.

Behaviour:
- Reset is asynchronous on rst_n_in low, with no wait for a clock edge. It sets:
  - state IDLE, pc_out=RESET_PC;
  - imem_req_out=0, pc_src_out=0, flush_if_id_out=0, flush_id_ex_out=0;
  - misalign_err_out=0, taken_count_out=0, flush counter=0.
- Define taken = branch_valid_in & (unconditional_branch_in | (conditional_branch_in & alu_main_is_zero_in)). It is evaluated only in FETCH.
- States:
  - IDLE:
    - imem_req_out=0.
    - Unconditionally go to FETCH next cycle; this gives one dead cycle after reset release.
  - FETCH:
    - imem_req_out=1. Priority per cycle is taken > stall > ready.
    - taken: pc_out <= {branch_target_in[ADDR_W-1:2],2'b00}. pc_src_out <= 1 for exactly one cycle. If target[1:0]!=0, set misalign_err_out <= 1. Increment taken_count_out, saturating at all-ones. Load counter = FLUSH_SLOTS and go to FLUSH. Stall and ready are ignored in this cycle.
    - stall_in=1 or imem_ready_in=0: hold pc_out; stay in FETCH; imem_req_out remains 1.
    - imem_ready_in=1 and no stall: pc_out <= pc_out + 4, modulo 2^ADDR_W, so all-ones minus 3 wraps to 0.
  - FLUSH:
    - imem_req_out=0.
    - flush_if_id_out=1 and flush_id_ex_out=1, registered. They are first high in the cycle after the taken decision and stay high for exactly FLUSH_SLOTS cycles.
    - Counter decrements each cycle; when it reaches 0, go to FETCH. The first FETCH cycle presents the target PC.
    - Branch inputs, stall_in and imem_ready_in are ignored; pc_out is held.
- Outputs are registered; no combinational path runs from inputs to outputs.
- misalign_err_out clears only on reset.
- Reset mid-FLUSH: all flushes drop immediately and pc_out=RESET_PC; the sequence restarts at IDLE.
- If both unconditional_branch_in and conditional_branch_in are high, the branch is treated as taken regardless of the zero flag.
- branch_valid_in=0 suppresses taken even when the branch inputs are high.

Test Plan:
- Reset then ready=1, no stall, RESET_PC=0 -> IDLE for 1 cycle; req rises; pc_out reads 0,4,8,12 on successive cycles.
- imem_ready_in low for 3 cycles at pc=8 -> pc_out holds 8 with req=1; advances to 12 the cycle after ready returns. stall_in high for 2 cycles gives the same hold.
- Conditional branch, zero=0, target 0x100 -> no redirect, pc continues +4, no flush, count unchanged. With zero=1 -> pc_out=0x100 next cycle, pc_src_out pulses 1 cycle, flushes high exactly 2 cycles, req low for those 2 cycles, then fetch resumes at 0x100, count=1.
- Unconditional branch with stall_in=1 in the same cycle, target 0x203 -> branch wins; pc_out=0x200; misalign_err_out=1 and stays 1.
- Taken branch, then another taken branch asserted during FLUSH -> second branch ignored; count=1; fetch resumes at the first target. Assert rst_n_in during FLUSH -> flushes drop asynchronously; pc_out=RESET_PC; error and count cleared.
- Force pc_out to 2^ADDR_W-4 via a branch target, ready=1 -> next pc_out=0.
- CNT_W=2 with 5 taken branches -> taken_count_out saturates at 3.
